// File: rtl/interact_regfile_if.sv
// APF bridge bus between the host bridge and the interact register bank.
// Reads return on bridge_rd_data/bridge_rd_hit one clock after the strobe.
interface interact_regfile_if;
   logic [31:0] bridge_addr;
   logic        bridge_wr;
   logic [31:0] bridge_wr_data;
   logic        bridge_rd;
   logic [31:0] bridge_rd_data;
   logic        bridge_rd_hit;

   modport master (
      output bridge_addr, bridge_wr, bridge_wr_data, bridge_rd,
      input  bridge_rd_data, bridge_rd_hit
   );

   modport slave (
      input  bridge_addr, bridge_wr, bridge_wr_data, bridge_rd,
      output bridge_rd_data, bridge_rd_hit
   );
endinterface

// File: rtl/interact_regfile.sv
// Parametrised bridge register bank with update strobes and a timed core-reset window.
// Reads have one-clock latency; there is no backpressure, so every strobe is taken.
module interact_regfile #(
   parameter int                  NUM_REGS     = 8,
   parameter logic [31:0]         BASE_ADDR    = 32'hF1000000,
   parameter logic [31:0]         ADDR_STRIDE  = 32'h01000000,
   parameter logic [31:0]         CTRL_ADDR    = 32'hF0000000,
   parameter logic [NUM_REGS-1:0] RESET_MASK   = '0,
   parameter int                  RESET_CYCLES = 8000,
   parameter int                  CNT_W        = 16
) (
   input  logic                     clk_74a,
   input  logic                     reset,
   interact_regfile_if.slave        bridge,
   output logic [32*NUM_REGS-1:0]   regs_flat,
   output logic [NUM_REGS-1:0]      reg_updated,
   output logic                     core_reset_n,
   output logic                     reset_busy
);

   logic [31:0]         offset;
   logic [NUM_REGS-1:0] sel;
   logic                ctrl_hit;
   logic                trig;
   logic [31:0]         rd_mux;
   logic [31:0]         regs [NUM_REGS];
   logic [CNT_W-1:0]    cnt;

   // An exact match against each aligned slot covers both the window and alignment checks;
   // the unsigned subtraction makes addresses below the base wrap large and miss.
   always_comb begin
      offset   = bridge.bridge_addr - BASE_ADDR;
      ctrl_hit = (bridge.bridge_addr == CTRL_ADDR);
      sel      = '0;
      rd_mux   = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         sel[i] = (offset == 32'(i) * ADDR_STRIDE);
         if (sel[i]) rd_mux = rd_mux | regs[i];
      end
      trig = bridge.bridge_wr && (ctrl_hit || (|(sel & RESET_MASK)));
   end

   always_ff @(posedge clk_74a or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         reg_updated <= '0;
      end else begin
         reg_updated <= bridge.bridge_wr ? sel : '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (bridge.bridge_wr && sel[i]) regs[i] <= bridge.bridge_wr_data;
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_flat[32*g +: 32] = regs[g];
   end

   // Read data is taken from the pre-edge register state, so a same-cycle write is not visible.
   always_ff @(posedge clk_74a or posedge reset) begin
      if (reset) begin
         bridge.bridge_rd_data <= '0;
         bridge.bridge_rd_hit  <= 1'b0;
      end else begin
         bridge.bridge_rd_hit <= 1'b0;
         if (bridge.bridge_rd) begin
            if (|sel) begin
               bridge.bridge_rd_data <= rd_mux;
               bridge.bridge_rd_hit  <= 1'b1;
            end else if (ctrl_hit) begin
               bridge.bridge_rd_data <= {30'b0, reset_busy, core_reset_n};
               bridge.bridge_rd_hit  <= 1'b1;
            end
         end
      end
   end

   // A trigger loads RESET_CYCLES-1 because the trigger edge itself is the first low cycle.
   always_ff @(posedge clk_74a or posedge reset) begin
      if (reset) begin
         cnt          <= CNT_W'(RESET_CYCLES);
         core_reset_n <= 1'b0;
         reset_busy   <= 1'b1;
      end else if (trig) begin
         cnt          <= CNT_W'(RESET_CYCLES - 1);
         core_reset_n <= 1'b0;
         reset_busy   <= 1'b1;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end else begin
         core_reset_n <= 1'b1;
         reset_busy   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_interact_regfile.sv
// Scoreboard bench for interact_regfile with NUM_REGS=4, RESET_MASK=4'b1001, RESET_CYCLES=16.
module tb_interact_regfile;
   localparam int NR = 4;
   localparam int RC = 16;

   logic clk_74a = 1'b0;
   logic reset   = 1'b1;
   always #5 clk_74a = ~clk_74a;

   interact_regfile_if bus ();
   logic [32*NR-1:0] regs_flat;
   logic [NR-1:0]    reg_updated;
   logic             core_reset_n;
   logic             reset_busy;

   interact_regfile #(
      .NUM_REGS(NR), .RESET_MASK(4'b1001), .RESET_CYCLES(RC)
   ) dut (
      .clk_74a(clk_74a), .reset(reset), .bridge(bus),
      .regs_flat(regs_flat), .reg_updated(reg_updated),
      .core_reset_n(core_reset_n), .reset_busy(reset_busy)
   );

   typedef struct packed {
      logic        hit;
      logic [31:0] data;
   } rd_exp_t;

   rd_exp_t     sbq[$];
   logic [31:0] m_regs [NR];
   logic [31:0] m_last;
   logic [31:0] m_ctrl;
   int          n_cmp = 0;
   int          n_fail = 0;

   function automatic int decode(input logic [31:0] a);
      logic [31:0] off;
      off = a - 32'hF1000000;
      if (a == 32'hF0000000) return -2;
      if (off < 32'h04000000 && off[23:0] == 24'h0) return int'(off[25:24]);
      return -1;
   endfunction

   function automatic logic [32*NR-1:0] m_flat();
      logic [32*NR-1:0] f;
      for (int i = 0; i < NR; i++) f[32*i +: 32] = m_regs[i];
      return f;
   endfunction

   task automatic tick();
      @(posedge clk_74a);
      #1;
   endtask

   task automatic idle();
      bus.bridge_rd = 1'b0;
      bus.bridge_wr = 1'b0;
   endtask

   task automatic issue_read(input logic [31:0] a);
      int k;
      rd_exp_t e;
      k = decode(a);
      bus.bridge_rd   = 1'b1;
      bus.bridge_addr = a;
      if (k >= 0) begin
         e.hit = 1'b1; e.data = m_regs[k];
      end else if (k == -2) begin
         e.hit = 1'b1; e.data = m_ctrl;
      end else begin
         e.hit = 1'b0; e.data = m_last;
      end
      m_last = e.data;
      sbq.push_back(e);
   endtask

   task automatic issue_write(input logic [31:0] a, input logic [31:0] d);
      int k;
      k = decode(a);
      bus.bridge_wr      = 1'b1;
      bus.bridge_addr    = a;
      bus.bridge_wr_data = d;
      if (k >= 0) m_regs[k] = d;
   endtask

   task automatic test_reset();
      int n;
      rd_exp_t e;
      repeat (2) tick();
      n_cmp++;
      if (regs_flat !== '0 || reg_updated !== '0) begin
         n_fail++;
         $display("FAIL reset_regs: regs_flat=%h reg_updated=%b, want 0/0", regs_flat, reg_updated);
      end
      n_cmp++;
      if (bus.bridge_rd_data !== 32'h0 || bus.bridge_rd_hit !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_rd: data=%h hit=%b, want 0/0", bus.bridge_rd_data, bus.bridge_rd_hit);
      end
      n_cmp++;
      if (core_reset_n !== 1'b0 || reset_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_win: core_reset_n=%b busy=%b, want 0/1", core_reset_n, reset_busy);
      end
      reset = 1'b0;
      n = 0;
      while (core_reset_n !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      n_cmp++;
      if (n != RC + 1 || reset_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL poweron_len: rose after %0d edges busy=%b, want %0d/0", n, reset_busy, RC + 1);
      end
      m_ctrl = 32'h1;
      for (int i = 0; i < NR; i++) begin
         issue_read(32'hF1000000 + 32'(i) * 32'h01000000);
         tick();
         idle();
         e = sbq.pop_front();
         n_cmp++;
         if (bus.bridge_rd_hit !== e.hit || bus.bridge_rd_data !== e.data) begin
            n_fail++;
            $display("FAIL poweron_rd%0d: data=%h hit=%b, want %h/%b", i, bus.bridge_rd_data, bus.bridge_rd_hit, e.data, e.hit);
         end
      end
   endtask

   task automatic test_write();
      rd_exp_t e;
      issue_write(32'hF2000000, 32'hDEADBEEF);
      tick();
      idle();
      n_cmp++;
      if (regs_flat[63:32] !== 32'hDEADBEEF || reg_updated !== 4'b0010 || core_reset_n !== 1'b1) begin
         n_fail++;
         $display("FAIL write_reg1: reg1=%h upd=%b crn=%b, want deadbeef/0010/1", regs_flat[63:32], reg_updated, core_reset_n);
      end
      tick();
      n_cmp++;
      if (reg_updated !== 4'b0000) begin
         n_fail++;
         $display("FAIL upd_pulse_len: upd=%b, want 0000", reg_updated);
      end
      issue_read(32'hF2000000);
      tick();
      idle();
      e = sbq.pop_front();
      n_cmp++;
      if (bus.bridge_rd_hit !== e.hit || bus.bridge_rd_data !== e.data) begin
         n_fail++;
         $display("FAIL write_readback: data=%h hit=%b, want %h/%b", bus.bridge_rd_data, bus.bridge_rd_hit, e.data, e.hit);
      end
   endtask

   task automatic test_masked_reset();
      int n;
      issue_write(32'hF4000000, 32'h5);
      tick();
      idle();
      n_cmp++;
      if (regs_flat[127:96] !== 32'h5 || reg_updated !== 4'b1000 || core_reset_n !== 1'b0 || reset_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL masked_trig: reg3=%h upd=%b crn=%b busy=%b, want 5/1000/0/1", regs_flat[127:96], reg_updated, core_reset_n, reset_busy);
      end
      n = 0;
      while (core_reset_n !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      n_cmp++;
      if (n != RC) begin
         n_fail++;
         $display("FAIL masked_len: low %0d more edges, want %0d", n, RC);
      end
   endtask

   task automatic test_retrigger();
      int n;
      rd_exp_t e;
      issue_write(32'hF4000000, 32'h5);
      tick();
      idle();
      m_ctrl = 32'h2;
      for (int c = 1; c <= 9; c++) begin
         if (c == 5) issue_read(32'hF0000000);
         tick();
         idle();
         if (c == 5) begin
            e = sbq.pop_front();
            n_cmp++;
            if (bus.bridge_rd_hit !== e.hit || bus.bridge_rd_data !== e.data) begin
               n_fail++;
               $display("FAIL ctrl_mid: data=%h hit=%b, want %h/%b", bus.bridge_rd_data, bus.bridge_rd_hit, e.data, e.hit);
            end
         end
      end
      issue_write(32'hF0000000, 32'hFFFFFFFF);
      tick();
      idle();
      n_cmp++;
      if (regs_flat !== m_flat() || reg_updated !== 4'b0000) begin
         n_fail++;
         $display("FAIL ctrl_write_regs: regs=%h upd=%b, want %h/0000", regs_flat, reg_updated, m_flat());
      end
      n = 0;
      while (core_reset_n !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      n_cmp++;
      if (n != RC) begin
         n_fail++;
         $display("FAIL retrig_len: low %0d more edges, want %0d", n, RC);
      end
      m_ctrl = 32'h1;
      issue_read(32'hF0000000);
      tick();
      idle();
      e = sbq.pop_front();
      n_cmp++;
      if (bus.bridge_rd_hit !== e.hit || bus.bridge_rd_data !== e.data) begin
         n_fail++;
         $display("FAIL ctrl_after: data=%h hit=%b, want %h/%b", bus.bridge_rd_data, bus.bridge_rd_hit, e.data, e.hit);
      end
   endtask

   task automatic test_miss();
      logic [31:0] addrs [3];
      rd_exp_t e;
      addrs[0] = 32'hF1000004;
      addrs[1] = 32'hF5000000;
      addrs[2] = 32'h00000000;
      for (int i = 0; i < 3; i++) begin
         issue_read(addrs[i]);
         tick();
         idle();
         e = sbq.pop_front();
         n_cmp++;
         if (bus.bridge_rd_hit !== e.hit || bus.bridge_rd_data !== e.data) begin
            n_fail++;
            $display("FAIL miss_rd_%h: data=%h hit=%b, want %h/%b", addrs[i], bus.bridge_rd_data, bus.bridge_rd_hit, e.data, e.hit);
         end
      end
      for (int i = 0; i < 3; i++) begin
         issue_write(addrs[i], 32'hA5A5A5A5);
         tick();
         idle();
         n_cmp++;
         if (reg_updated !== 4'b0000 || core_reset_n !== 1'b1 || regs_flat !== m_flat()) begin
            n_fail++;
            $display("FAIL miss_wr_%h: upd=%b crn=%b regs=%h, want 0000/1/%h", addrs[i], reg_updated, core_reset_n, regs_flat, m_flat());
         end
      end
   endtask

   task automatic test_same_cycle();
      rd_exp_t e;
      issue_write(32'hF3000000, 32'h7);
      tick();
      idle();
      issue_read(32'hF3000000);
      issue_write(32'hF3000000, 32'h9);
      tick();
      idle();
      e = sbq.pop_front();
      n_cmp++;
      if (bus.bridge_rd_hit !== e.hit || bus.bridge_rd_data !== e.data) begin
         n_fail++;
         $display("FAIL rw_same_rd: data=%h hit=%b, want %h/%b", bus.bridge_rd_data, bus.bridge_rd_hit, e.data, e.hit);
      end
      n_cmp++;
      if (regs_flat[95:64] !== 32'h9 || reg_updated !== 4'b0100) begin
         n_fail++;
         $display("FAIL rw_same_wr: reg2=%h upd=%b, want 9/0100", regs_flat[95:64], reg_updated);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [5];
      rd_exp_t e;
      addrs[0] = 32'hF1000000;
      addrs[1] = 32'hF2000000;
      addrs[2] = 32'hF5000000;
      addrs[3] = 32'hF3000000;
      addrs[4] = 32'hF4000000;
      for (int i = 0; i < 5; i++) begin
         issue_read(addrs[i]);
         tick();
         e = sbq.pop_front();
         n_cmp++;
         if (bus.bridge_rd_hit !== e.hit || bus.bridge_rd_data !== e.data) begin
            n_fail++;
            $display("FAIL b2b_%0d: data=%h hit=%b, want %h/%b", i, bus.bridge_rd_data, bus.bridge_rd_hit, e.data, e.hit);
         end
      end
      idle();
   endtask

   task automatic test_async_reset();
      int n;
      rd_exp_t e;
      issue_write(32'hF0000000, 32'h0);
      tick();
      idle();
      n_cmp++;
      if (core_reset_n !== 1'b0 || reset_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL ctrl_trig: crn=%b busy=%b, want 0/1", core_reset_n, reset_busy);
      end
      repeat (3) tick();
      issue_read(32'hF2000000);
      tick();
      idle();
      e = sbq.pop_front();
      n_cmp++;
      if (bus.bridge_rd_hit !== e.hit || bus.bridge_rd_data !== e.data) begin
         n_fail++;
         $display("FAIL pre_arst_rd: data=%h hit=%b, want %h/%b", bus.bridge_rd_data, bus.bridge_rd_hit, e.data, e.hit);
      end
      #1;
      reset = 1'b1;
      #1;
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_last = '0;
      n_cmp++;
      if (regs_flat !== '0 || bus.bridge_rd_data !== 32'h0 || bus.bridge_rd_hit !== 1'b0 ||
          core_reset_n !== 1'b0 || reset_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL arst_async: regs=%h data=%h hit=%b crn=%b busy=%b, want 0/0/0/0/1",
                  regs_flat, bus.bridge_rd_data, bus.bridge_rd_hit, core_reset_n, reset_busy);
      end
      tick();
      reset = 1'b0;
      n = 0;
      while (core_reset_n !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      n_cmp++;
      if (n != RC + 1) begin
         n_fail++;
         $display("FAIL arst_restart: rose after %0d edges, want %0d", n, RC + 1);
      end
   endtask

   initial begin
      idle();
      bus.bridge_addr    = '0;
      bus.bridge_wr_data = '0;
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_last = '0;
      m_ctrl = '0;
      test_reset();
      test_write();
      test_masked_reset();
      test_retrigger();
      test_miss();
      test_same_cycle();
      test_back_to_back();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
